// File: rtl/multi_sensor_monitor.sv
// rtl/multi_sensor_monitor.sv - round-robin multi-channel sensor averager with threshold alerts
//
// Purpose: scans NUM_CH externally multiplexed sensor channels, averages
// 2^AVG_LOG2 samples per channel and runs a per-channel threshold filter
// with persistence and hysteresis.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   en                  scan enable; dropping it aborts the current channel
//   sample_data/_valid  reading of the channel currently on ch_sel
//   ch_sel              channel select to the external mux
//   thr_we/thr_ch/_val  threshold write port
//   avg_valid/_ch/_data one-cycle average report
//   alert_vec           per-channel alert state
//   alert_level         popcount of alert_vec, saturated at 7
//   harvest_alert       alert_level >= ALERT_MIN
module multi_sensor_monitor #(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 8,
    parameter int AVG_LOG2   = 2,
    parameter int SETTLE_CYC = 2,
    parameter int HYST       = 4,
    parameter int PERSIST    = 2,
    parameter int ALERT_MIN  = 1,
    localparam int CH_W      = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              sample_valid,
    output logic [CH_W-1:0]   ch_sel,
    input  logic              thr_we,
    input  logic [CH_W-1:0]   thr_ch,
    input  logic [DATA_W-1:0] thr_val,
    output logic              avg_valid,
    output logic [CH_W-1:0]   avg_ch,
    output logic [DATA_W-1:0] avg_data,
    output logic [NUM_CH-1:0] alert_vec,
    output logic [2:0]        alert_level,
    output logic              harvest_alert
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACQ    = 2'd2,
        ST_EVAL   = 2'd3
    } state_t;

    localparam int ACC_W  = DATA_W + AVG_LOG2;
    // One extra bit so the sample counter exists even when AVG_LOG2 is 0.
    localparam int SCNT_W = AVG_LOG2 + 1;

    localparam logic [SCNT_W-1:0] SAMP_LAST   = SCNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE_CYC - 1);
    localparam logic [2:0]        PERSIST_MAX = 3'(PERSIST);
    localparam logic [DATA_W:0]   HYST_EXT    = (DATA_W + 1)'(HYST);
    localparam logic [CH_W-1:0]   CH_LAST     = CH_W'(NUM_CH - 1);
    localparam logic [CH_W:0]     NUM_CH_EXT  = (CH_W + 1)'(NUM_CH);
    localparam logic [3:0]        ALERT_MIN_W = 4'(ALERT_MIN);

    state_t              state_q, state_d;
    logic [CH_W-1:0]     ch_sel_q, ch_sel_d;
    logic [3:0]          settle_cnt_q, settle_cnt_d;
    logic [SCNT_W-1:0]   samp_cnt_q, samp_cnt_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    acc_sum;
    logic                avg_valid_q, avg_valid_d;
    logic [CH_W-1:0]     avg_ch_q, avg_ch_d;
    logic [DATA_W-1:0]   avg_data_q, avg_data_d;
    logic [DATA_W-1:0]   thr_q [NUM_CH];
    logic [DATA_W-1:0]   thr_d [NUM_CH];
    logic [2:0]          pcnt_q [NUM_CH];
    logic [2:0]          pcnt_d [NUM_CH];
    logic [NUM_CH-1:0]   alert_q, alert_d;
    logic [2:0]          alert_level_q, alert_level_d;
    logic                harvest_q, harvest_d;

    logic                eval_fire;
    logic                over_thr;
    logic                hyst_clear;
    logic                thr_wr_ok;
    logic [2:0]          pcnt_inc;
    logic [3:0]          pop;

    assign acc_sum = acc_q + ACC_W'(sample_data);

    // Scan sequencer
    always_comb begin
        state_d      = state_q;
        ch_sel_d     = ch_sel_q;
        settle_cnt_d = settle_cnt_q;
        samp_cnt_d   = samp_cnt_q;
        acc_d        = acc_q;
        avg_valid_d  = 1'b0;
        avg_ch_d     = avg_ch_q;
        avg_data_d   = avg_data_q;
        eval_fire    = 1'b0;
        if (state_q != ST_IDLE && !en) begin
            // Abort: partial accumulation is dropped, channel is kept.
            state_d    = ST_IDLE;
            acc_d      = '0;
            samp_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en) begin
                        state_d      = ST_SETTLE;
                        settle_cnt_d = 4'd0;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        state_d    = ST_ACQ;
                        acc_d      = '0;
                        samp_cnt_d = '0;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 4'd1;
                    end
                end
                ST_ACQ: begin
                    if (sample_valid) begin
                        acc_d      = acc_sum;
                        samp_cnt_d = samp_cnt_q + 1'b1;
                        if (samp_cnt_q == SAMP_LAST) begin
                            state_d     = ST_EVAL;
                            avg_valid_d = 1'b1;
                            avg_ch_d    = ch_sel_q;
                            avg_data_d  = acc_sum[ACC_W-1:AVG_LOG2];
                        end
                    end
                end
                ST_EVAL: begin
                    eval_fire    = 1'b1;
                    state_d      = ST_SETTLE;
                    settle_cnt_d = 4'd0;
                    ch_sel_d     = (ch_sel_q == CH_LAST) ? '0 : ch_sel_q + 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Per-channel persistence/hysteresis filter and threshold writes
    assign over_thr   = avg_data_q > thr_q[ch_sel_q];
    // Widened by one bit so avg + HYST cannot wrap near full scale.
    assign hyst_clear = ({1'b0, avg_data_q} + HYST_EXT) <= {1'b0, thr_q[ch_sel_q]};
    assign pcnt_inc   = (pcnt_q[ch_sel_q] >= PERSIST_MAX) ? PERSIST_MAX
                                                          : pcnt_q[ch_sel_q] + 3'd1;
    assign thr_wr_ok  = {1'b0, thr_ch} < NUM_CH_EXT;

    always_comb begin
        thr_d   = thr_q;
        pcnt_d  = pcnt_q;
        alert_d = alert_q;
        if (eval_fire) begin
            if (over_thr) begin
                pcnt_d[ch_sel_q] = pcnt_inc;
                if (pcnt_inc == PERSIST_MAX) begin
                    alert_d[ch_sel_q] = 1'b1;
                end
            end else begin
                pcnt_d[ch_sel_q] = 3'd0;
                if (hyst_clear) begin
                    alert_d[ch_sel_q] = 1'b0;
                end
            end
        end
        // Applied after the filter so a colliding write's clear wins;
        // the filter above already used the old threshold.
        if (thr_we && thr_wr_ok) begin
            thr_d[thr_ch]   = thr_val;
            pcnt_d[thr_ch]  = 3'd0;
            alert_d[thr_ch] = 1'b0;
        end
    end

    // Aggregate alert level
    always_comb begin
        pop = 4'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            pop = pop + {3'b000, alert_q[i]};
        end
        alert_level_d = (pop > 4'd7) ? 3'd7 : pop[2:0];
        harvest_d     = {1'b0, alert_level_d} >= ALERT_MIN_W;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ch_sel_q      <= '0;
            settle_cnt_q  <= 4'd0;
            samp_cnt_q    <= '0;
            acc_q         <= '0;
            avg_valid_q   <= 1'b0;
            avg_ch_q      <= '0;
            avg_data_q    <= '0;
            alert_q       <= '0;
            alert_level_q <= 3'd0;
            harvest_q     <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                thr_q[i]  <= '1;
                pcnt_q[i] <= 3'd0;
            end
        end else begin
            state_q       <= state_d;
            ch_sel_q      <= ch_sel_d;
            settle_cnt_q  <= settle_cnt_d;
            samp_cnt_q    <= samp_cnt_d;
            acc_q         <= acc_d;
            avg_valid_q   <= avg_valid_d;
            avg_ch_q      <= avg_ch_d;
            avg_data_q    <= avg_data_d;
            alert_q       <= alert_d;
            alert_level_q <= alert_level_d;
            harvest_q     <= harvest_d;
            for (int i = 0; i < NUM_CH; i++) begin
                thr_q[i]  <= thr_d[i];
                pcnt_q[i] <= pcnt_d[i];
            end
        end
    end

    assign ch_sel        = ch_sel_q;
    assign avg_valid     = avg_valid_q;
    assign avg_ch        = avg_ch_q;
    assign avg_data      = avg_data_q;
    assign alert_vec     = alert_q;
    assign alert_level   = alert_level_q;
    assign harvest_alert = harvest_q;

endmodule

// File: tb/tb_multi_sensor_monitor.sv
// tb/tb_multi_sensor_monitor.sv - directed self-checking bench for multi_sensor_monitor
module tb_multi_sensor_monitor;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] sample_data;
    logic       sample_valid;
    logic [1:0] ch_sel;
    logic       thr_we;
    logic [1:0] thr_ch;
    logic [7:0] thr_val;
    logic       avg_valid;
    logic [1:0] avg_ch;
    logic [7:0] avg_data;
    logic [3:0] alert_vec;
    logic [2:0] alert_level;
    logic       harvest_alert;

    logic       use_tbl;
    logic [7:0] man_data;
    logic [7:0] tbl [4];

    int checks;
    int errors;

    assign sample_data = use_tbl ? tbl[ch_sel] : man_data;

    multi_sensor_monitor #(
        .NUM_CH    (4),
        .DATA_W    (8),
        .AVG_LOG2  (2),
        .SETTLE_CYC(2),
        .HYST      (4),
        .PERSIST   (2),
        .ALERT_MIN (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .ch_sel       (ch_sel),
        .thr_we       (thr_we),
        .thr_ch       (thr_ch),
        .thr_val      (thr_val),
        .avg_valid    (avg_valid),
        .avg_ch       (avg_ch),
        .avg_data     (avg_data),
        .alert_vec    (alert_vec),
        .alert_level  (alert_level),
        .harvest_alert(harvest_alert)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_avg(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (avg_valid === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_avg_ch(input int ch, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (avg_valid === 1'b1 && int'(avg_ch) == ch) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ch_sel"},    ch_sel,        0);
        chk({tag, "_avg_valid"}, avg_valid,     0);
        chk({tag, "_avg_ch"},    avg_ch,        0);
        chk({tag, "_avg_data"},  avg_data,      0);
        chk({tag, "_alert_vec"}, alert_vec,     0);
        chk({tag, "_level"},     alert_level,   0);
        chk({tag, "_harvest"},   harvest_alert, 0);
    endtask

    initial begin
        int n;
        logic seen_avg;
        logic ch_moved;

        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        en           = 1'b0;
        sample_valid = 1'b0;
        thr_we       = 1'b0;
        thr_ch       = 2'd0;
        thr_val      = 8'd0;
        use_tbl      = 1'b1;
        man_data     = 8'd0;
        for (int i = 0; i < 4; i++) tbl[i] = 8'hFF;

        // Power-on reset
        step();
        step();
        chk_reset_outputs("por");

        // Full-scale samples on default thresholds, then reset mid-ACQ
        en           = 1'b1;
        sample_valid = 1'b1;
        rst_n        = 1'b1;
        wait_avg(20, n);
        chk("first_latency", n, 7);
        chk("first_avg_ch", avg_ch, 0);
        chk("first_avg_data", avg_data, 8'hFF);
        repeat (4) step();
        chk("pre_reset_ch_sel", ch_sel, 1);
        #3 rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Continuous scan: wrap order, 7-cycle spacing, no default alerts
        for (int r = 0; r < 8; r++) begin
            wait_avg(20, n);
            chk("scan_spacing", n, 7);
            chk("scan_avg_ch", avg_ch, r % 4);
            chk("scan_avg_data", avg_data, 8'hFF);
            chk("scan_alert_vec", alert_vec, 0);
        end

        // Averaging on ch0, junk during SETTLE must be ignored
        rst_n = 1'b0;
        en    = 1'b0;
        step();
        step();
        use_tbl  = 1'b0;
        man_data = 8'hEE;
        en       = 1'b1;
        rst_n    = 1'b1;
        step();                 // SETTLE 1
        step();                 // SETTLE 2
        step(); man_data = 8'd10;
        step(); man_data = 8'd11;
        step(); man_data = 8'd12;
        step(); man_data = 8'd13;
        chk("avg_not_early", avg_valid, 0);
        step();
        chk("avg_valid_c7", avg_valid, 1);
        chk("avg_ch_c7", avg_ch, 0);
        chk("avg_data_c7", avg_data, 11);
        step();
        chk("avg_pulse_end", avg_valid, 0);
        chk("ch_sel_after", ch_sel, 1);

        // Hysteresis and persistence on ch1 (thr=100, HYST=4, PERSIST=2)
        use_tbl = 1'b1;
        tbl[0] = 8'd0; tbl[1] = 8'd101; tbl[2] = 8'd0; tbl[3] = 8'd0;
        thr_we  = 1'b1;
        thr_ch  = 2'd1;
        thr_val = 8'd100;
        step();
        thr_we = 1'b0;
        wait_avg_ch(1, 40, n);
        chk("hyst_r1_seen", (n > 0), 1);
        chk("hyst_r1_data", avg_data, 101);
        step();
        chk("hyst_r1_alert", alert_vec, 4'b0000);
        wait_avg_ch(1, 40, n);
        chk("hyst_r2_seen", (n > 0), 1);
        chk("hyst_r2_data", avg_data, 101);
        step();
        chk("hyst_r2_alert", alert_vec, 4'b0010);
        step();
        chk("hyst_r2_level", alert_level, 1);
        chk("hyst_r2_harvest_below_min", harvest_alert, 0);
        tbl[1] = 8'd98;
        wait_avg_ch(1, 40, n);
        chk("hyst_r3_data", avg_data, 98);
        step();
        chk("hyst_r3_alert_held", alert_vec, 4'b0010);
        tbl[1] = 8'd96;
        wait_avg_ch(1, 40, n);
        chk("hyst_r4_data", avg_data, 96);
        step();
        chk("hyst_r4_alert_cleared", alert_vec, 4'b0000);

        // Abort on ch2 after two accepted samples, then clean restart
        chk("abort_start_ch", ch_sel, 2);
        tbl[2] = 8'd200;
        step();                 // SETTLE 2
        step();                 // ACQ sample 1
        step();                 // ACQ sample 2
        step();
        en = 1'b0;
        seen_avg = 1'b0;
        ch_moved = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (avg_valid !== 1'b0) seen_avg = 1'b1;
            if (ch_sel !== 2'd2) ch_moved = 1'b1;
        end
        chk("abort_no_avg", seen_avg, 0);
        chk("abort_ch_moved", ch_moved, 0);
        chk("abort_ch_sel", ch_sel, 2);
        tbl[2] = 8'd40;
        en = 1'b1;
        wait_avg(20, n);
        chk("restart_latency", n, 7);
        chk("restart_avg_ch", avg_ch, 2);
        chk("restart_avg_data", avg_data, 40);

        // Aggregate level with ch0 and ch3 alerting, then colliding write
        tbl[0] = 8'd60; tbl[1] = 8'd0; tbl[3] = 8'd60;
        thr_we  = 1'b1;
        thr_ch  = 2'd0;
        thr_val = 8'd50;
        step();
        thr_ch  = 2'd3;
        step();
        thr_we  = 1'b0;
        wait_avg_ch(3, 40, n);
        chk("agg_ch3_r1_data", avg_data, 60);
        wait_avg_ch(3, 40, n);
        chk("agg_ch3_r2_seen", (n > 0), 1);
        wait_avg_ch(0, 40, n);
        chk("agg_ch0_r2_data", avg_data, 60);
        step();
        chk("agg_alert_vec", alert_vec, 4'b1001);
        step();
        chk("agg_level", alert_level, 2);
        chk("agg_harvest", harvest_alert, 1);
        wait_avg_ch(3, 40, n);
        chk("coll_ch3_data", avg_data, 60);
        thr_we  = 1'b1;
        thr_ch  = 2'd3;
        thr_val = 8'hFF;
        step();
        thr_we = 1'b0;
        chk("coll_alert_vec", alert_vec, 4'b0001);
        chk("coll_level_lag", alert_level, 2);
        step();
        chk("coll_level", alert_level, 1);
        chk("coll_harvest", harvest_alert, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_sensor_monitor.md
# multi_sensor_monitor

Parametrised multi-channel sensor acquisition and alert engine, the successor to the single-stream sensor front end of the precision-farming ASIC. It scans NUM_CH externally multiplexed sensor channels round-robin and averages 2^AVG_LOG2 samples per channel. Each average is compared against a per-channel programmable threshold with hysteresis and persistence filtering. It drives a per-channel alert vector, an aggregate alert level and the harvest alert line feeding the top-level status outputs.

## Interface
- NUM_CH, 4, channel count (2..8); CH_W = clog2(NUM_CH)
- DATA_W, 8, sample and threshold width
- AVG_LOG2, 2, log2 of samples averaged per channel (0..4)
- SETTLE_CYC, 2, cycles discarded after each channel switch (1..15)
- HYST, 4, hysteresis in LSBs
- PERSIST, 2, consecutive over-threshold averages needed to set an alert (1..7)
- ALERT_MIN, 1, alerting-channel count that asserts harvest_alert

- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  scan enable
- sample_data  in  DATA_W  reading of the channel on ch_sel
- sample_valid  in  1  sample_data valid this cycle
- ch_sel  out  CH_W  channel select to external mux
- thr_we  in  1  threshold write strobe
- thr_ch  in  CH_W  threshold write channel
- thr_val  in  DATA_W  threshold value
- avg_valid  out  1  one-cycle pulse, avg_data/avg_ch valid
- avg_ch  out  CH_W  channel of reported average
- avg_data  out  DATA_W  averaged sample
- alert_vec  out  NUM_CH  per-channel alert state
- alert_level  out  3  popcount(alert_vec), saturated at 7
- harvest_alert  out  1  alert_level >= ALERT_MIN

## Operation
- FSM: IDLE, SETTLE, ACQ, EVAL.
- IDLE: stays while en=0. When en=1, goes to SETTLE on the current ch_sel.
- SETTLE: counts SETTLE_CYC cycles and ignores sample_valid, then goes to ACQ.
- ACQ: each sample_valid cycle adds sample_data to an accumulator of DATA_W+AVG_LOG2 bits (cleared on ACQ entry). The 2^AVG_LOG2-th accepted sample moves the FSM to EVAL. On that same edge, avg_data = acc_sum >> AVG_LOG2 (truncating) and avg_ch = ch_sel are registered.
- EVAL: one cycle, avg_valid=1. On exit, the selected channel's filter updates, ch_sel advances (NUM_CH-1 wraps to 0), and the FSM goes to SETTLE.
- Per-channel filter:
  - avg_data > thr: the persistence counter increments, saturating at PERSIST. Reaching PERSIST sets alert.
  - avg_data <= thr: the counter clears.
  - An alert clears only when avg_data + HYST <= thr, computed at DATA_W+1 bits.
- Thresholds reset to all-ones, so no channel alerts by default.
- Threshold write to a channel: updates thr, clears that channel's counter and alert. A write with thr_ch >= NUM_CH is ignored.
- Write in the same cycle as EVAL for the same channel: EVAL compares against the old threshold, then the write's clear takes priority over the filter update.
- en=0 in any non-IDLE state: IDLE next cycle, accumulator discarded, no avg_valid. ch_sel, thresholds and alerts are retained. Re-enable restarts SETTLE on the same channel.
- alert_level and harvest_alert are registered from alert_vec.

## Timing
- Reset values:
  - state IDLE, ch_sel 0, avg_valid 0, avg_ch 0, avg_data 0
  - alert_vec 0, alert_level 0, harvest_alert 0
  - counters 0, thresholds all-ones
- With continuous sample_valid, each channel takes SETTLE_CYC + 2^AVG_LOG2 + 1 cycles (7 by default). avg_valid rises exactly that many cycles after the first SETTLE cycle.
- alert_vec changes on the edge ending EVAL, i.e. 1 cycle after avg_valid.
- alert_level and harvest_alert follow 1 cycle later, i.e. 2 cycles after avg_valid.
- Gaps in sample_valid stretch ACQ with no other effect.
- A threshold write takes effect on the next edge. Clearing an alert via write is reflected in alert_level/harvest_alert one cycle after that.

## Test plan
- Reset: hold rst_n=0 mid-ACQ -> all outputs at reset values immediately. Then release with en=1 and constant 0xFF samples on default thresholds -> avg_data=0xFF each round, alert_vec stays 0.
- Averaging (defaults): ch0 samples 10,11,12,13 contiguous -> avg_valid on cycle 7 after SETTLE entry, avg_ch=0, avg_data=11; ch_sel=1 the next cycle.
- Hysteresis and persistence: thr[1]=100; ch1 averages 101 -> alert 0; 101 -> alert_vec[1]=1; 98 -> stays 1; 96 -> clears.
- Wrap: NUM_CH=4 continuous scan -> avg_ch sequence 0,1,2,3,0,1; no gaps beyond 7 cycles per channel.
- Abort: drop en after 2 ACQ samples on ch2 -> no avg_valid, ch_sel=2. Re-enable with samples 40,40,40,40 -> avg_data=40, not contaminated by pre-abort samples.
- Aggregate and collision: ALERT_MIN=2; ch0 and ch3 alerting -> alert_level=2, harvest_alert=1. Write thr[3]=0xFF in the same cycle as EVAL for ch3 -> alert_vec[3]=0, alert_level=1, harvest_alert=0 two cycles later.
